// File: rtl/reg128_loader_if.sv
// Beat-in / word-out bundle between a 32-bit beat source and the 128-bit register loader.
// The master drives beats and abort; the slave returns ready, the assembled word and status.
interface reg128_loader_if #(
  parameter int WORD_W = 32,
  parameter int BEATS  = 4
);
  localparam int CNT_W = $clog2(BEATS);

  logic [WORD_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    abort;
  logic [WORD_W*BEATS-1:0] D;
  logic                    wr;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    busy;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, D, wr, beat_cnt, busy
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, D, wr, beat_cnt, busy
  );
endinterface

// File: rtl/reg128_loader.sv
// Packs BEATS words LSB-lane first and pulses wr with the full word one cycle after the last beat.
// in_ready is low only in the COMMIT cycle, so continuous input yields one word per BEATS+1 cycles.
module reg128_loader #(
  parameter int WORD_W = 32,
  parameter int BEATS  = 4
) (
  input  logic            clk,
  input  logic            clr,
  reg128_loader_if.slave  bus
);
  localparam int CNT_W = $clog2(BEATS);
  localparam int DW    = WORD_W * BEATS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      d_q     <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, FILL: begin
        // abort wins over a beat presented in the same cycle
        if (bus.abort) begin
          state_d = IDLE;
          d_d     = '0;
          cnt_d   = '0;
        end else if (bus.in_valid) begin
          d_d[int'(cnt_q)*WORD_W +: WORD_W] = bus.in_data;
          if (cnt_q == LAST) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            state_d = FILL;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        d_d     = '0;
      end
      default: begin
        state_d = IDLE;
        d_d     = '0;
        cnt_d   = '0;
      end
    endcase
    wr_d = (state_d == COMMIT);
  end

  assign bus.in_ready = (state_q != COMMIT);
  assign bus.D        = d_q;
  assign bus.wr       = wr_q;
  assign bus.beat_cnt = cnt_q;
  assign bus.busy     = (cnt_q != '0) || (state_q == COMMIT);
endmodule
